// File: rtl/axi_perf_monitor_pkg.sv
// Default AXI4 request/response bundles for the performance monitor.
// Narrow payloads; the monitor only looks at IDs, last flags and handshakes.
package axi_perf_monitor_pkg;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
    } ax_chan_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } w_chan_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } b_chan_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_chan_t;

    typedef struct packed {
        ax_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ax_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axi_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } axi_rsp_t;

endpackage

// File: rtl/axi_perf_monitor.sv
// Passive AXI4 latency/beat monitor with per-ID timestamp FIFOs and windowed snapshots.
// Define AXI_PERF_MONITOR_MIN_LAT_EN to add per-window minimum latency tracking.
module axi_perf_monitor
    import axi_perf_monitor_pkg::*;
#(
    parameter type         req_t          = axi_req_t,
    parameter type         rsp_t          = axi_rsp_t,
    parameter int unsigned AxiIdWidth     = 4,
    parameter int unsigned NumIds         = 4,
    parameter int unsigned MaxOutstanding = 8,
    parameter int unsigned CntWidth       = 32,
    parameter int unsigned WindowCycles   = 1024
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_i,
    input  logic                clear_i,
    input  logic                snap_i,
    input  req_t                req_i,
    input  rsp_t                rsp_i,
    output logic [CntWidth-1:0] ar_in_flight_o,
    output logic [CntWidth-1:0] aw_in_flight_o,
    output logic [CntWidth-1:0] r_beats_o,
    output logic [CntWidth-1:0] w_beats_o,
    output logic [CntWidth-1:0] rd_txn_o,
    output logic [CntWidth-1:0] wr_txn_o,
    output logic [CntWidth-1:0] rd_lat_sum_o,
    output logic [CntWidth-1:0] wr_lat_sum_o,
    output logic [CntWidth-1:0] rd_lat_max_o,
    output logic [CntWidth-1:0] wr_lat_max_o,
    output logic [CntWidth-1:0] rd_lat_min_o,
    output logic [CntWidth-1:0] wr_lat_min_o,
    output logic                stats_valid_o,
    output logic                overflow_o,
    output logic                underflow_o
);

    localparam int unsigned IdxW = (NumIds > 1) ? $clog2(NumIds) : 1;
    localparam int unsigned PtrW = $clog2(MaxOutstanding);
    localparam int unsigned OccW = $clog2(MaxOutstanding + 1);

    typedef logic [CntWidth-1:0] cnt_t;
    typedef logic [PtrW-1:0]     ptr_t;
    typedef logic [OccW-1:0]     occ_t;
    typedef enum logic { IDLE, RUN } state_t;

    localparam cnt_t Ones = {CntWidth{1'b1}};

    function automatic cnt_t sat_add(cnt_t a, cnt_t b);
        logic [CntWidth:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CntWidth] ? Ones : s[CntWidth-1:0];
    endfunction

    function automatic ptr_t ptr_inc(ptr_t p);
        return (p == ptr_t'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
    endfunction

    logic unused_ok;
    assign unused_ok = ^{req_i, rsp_i};

    logic [AxiIdWidth-1:0] ar_id, aw_id, r_id, b_id;
    logic [IdxW-1:0]       ar_slot, aw_slot, r_slot, b_slot;
    logic                  ar_hs, aw_hs, r_hs, w_hs, b_hs, r_last;

    assign ar_id   = req_i.ar.id;
    assign aw_id   = req_i.aw.id;
    assign r_id    = rsp_i.r.id;
    assign b_id    = rsp_i.b.id;
    assign ar_slot = ar_id[IdxW-1:0];
    assign aw_slot = aw_id[IdxW-1:0];
    assign r_slot  = r_id[IdxW-1:0];
    assign b_slot  = b_id[IdxW-1:0];
    assign ar_hs   = req_i.ar_valid & rsp_i.ar_ready;
    assign aw_hs   = req_i.aw_valid & rsp_i.aw_ready;
    assign w_hs    = req_i.w_valid & rsp_i.w_ready;
    assign r_hs    = rsp_i.r_valid & req_i.r_ready;
    assign b_hs    = rsp_i.b_valid & req_i.b_ready;
    assign r_last  = rsp_i.r.last;

    cnt_t cycle_q;
    cnt_t rd_mem_q [NumIds][MaxOutstanding];
    cnt_t wr_mem_q [NumIds][MaxOutstanding];
    ptr_t rd_wptr_q [NumIds];
    ptr_t rd_rptr_q [NumIds];
    ptr_t wr_wptr_q [NumIds];
    ptr_t wr_rptr_q [NumIds];
    occ_t rd_occ_q [NumIds];
    occ_t wr_occ_q [NumIds];
    logic [NumIds-1:0] rd_burst_q;
    logic [NumIds-1:0] rd_push, rd_pop, rd_empty, rd_full;
    logic [NumIds-1:0] wr_push, wr_pop, wr_empty, wr_full;
    logic ovf_evt, udf_evt, rd_meas, wr_meas;
    cnt_t rd_lat, wr_lat, rd_sum_live, wr_sum_live;

    // A pop only counts when data is present; a push into a full FIFO
    // survives only if the head leaves in the same cycle.
    always_comb begin
        rd_sum_live = '0;
        wr_sum_live = '0;
        for (int s = 0; s < NumIds; s++) begin
            rd_empty[s] = (rd_occ_q[s] == '0);
            wr_empty[s] = (wr_occ_q[s] == '0);
            rd_full[s]  = (rd_occ_q[s] == occ_t'(MaxOutstanding));
            wr_full[s]  = (wr_occ_q[s] == occ_t'(MaxOutstanding));
            rd_pop[s]   = r_hs && r_last && (r_slot == IdxW'(s)) && !rd_empty[s];
            wr_pop[s]   = b_hs && (b_slot == IdxW'(s)) && !wr_empty[s];
            rd_push[s]  = ar_hs && (ar_slot == IdxW'(s)) && (!rd_full[s] || rd_pop[s]);
            wr_push[s]  = aw_hs && (aw_slot == IdxW'(s)) && (!wr_full[s] || wr_pop[s]);
            rd_sum_live = rd_sum_live + cnt_t'(rd_occ_q[s]);
            wr_sum_live = wr_sum_live + cnt_t'(wr_occ_q[s]);
        end
    end

    assign ovf_evt = (ar_hs && rd_full[ar_slot] && !rd_pop[ar_slot])
                  || (aw_hs && wr_full[aw_slot] && !wr_pop[aw_slot]);
    assign udf_evt = (r_hs && r_last && rd_empty[r_slot])
                  || (b_hs && wr_empty[b_slot]);
    assign rd_meas = r_hs && !rd_burst_q[r_slot] && !rd_empty[r_slot];
    assign wr_meas = b_hs && !wr_empty[b_slot];
    assign rd_lat  = cycle_q - rd_mem_q[r_slot][rd_rptr_q[r_slot]];
    assign wr_lat  = cycle_q - wr_mem_q[b_slot][wr_rptr_q[b_slot]];

    always_ff @(posedge clk_i) begin
        for (int s = 0; s < NumIds; s++) begin
            if (rd_push[s]) rd_mem_q[s][rd_wptr_q[s]] <= cycle_q;
            if (wr_push[s]) wr_mem_q[s][wr_wptr_q[s]] <= cycle_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cycle_q        <= '0;
            rd_burst_q     <= '0;
            overflow_o     <= 1'b0;
            underflow_o    <= 1'b0;
            ar_in_flight_o <= '0;
            aw_in_flight_o <= '0;
            for (int s = 0; s < NumIds; s++) begin
                rd_wptr_q[s] <= '0;
                rd_rptr_q[s] <= '0;
                rd_occ_q[s]  <= '0;
                wr_wptr_q[s] <= '0;
                wr_rptr_q[s] <= '0;
                wr_occ_q[s]  <= '0;
            end
        end else begin
            cycle_q        <= cycle_q + 1'b1;
            ar_in_flight_o <= rd_sum_live;
            aw_in_flight_o <= wr_sum_live;
            if (ovf_evt) overflow_o <= 1'b1;
            if (udf_evt) underflow_o <= 1'b1;
            if (r_hs) rd_burst_q[r_slot] <= !r_last;
            for (int s = 0; s < NumIds; s++) begin
                if (rd_push[s]) rd_wptr_q[s] <= ptr_inc(rd_wptr_q[s]);
                if (rd_pop[s])  rd_rptr_q[s] <= ptr_inc(rd_rptr_q[s]);
                if (wr_push[s]) wr_wptr_q[s] <= ptr_inc(wr_wptr_q[s]);
                if (wr_pop[s])  wr_rptr_q[s] <= ptr_inc(wr_rptr_q[s]);
                rd_occ_q[s] <= rd_occ_q[s] + occ_t'(rd_push[s]) - occ_t'(rd_pop[s]);
                wr_occ_q[s] <= wr_occ_q[s] + occ_t'(wr_push[s]) - occ_t'(wr_pop[s]);
            end
        end
    end

    state_t state_q, state_d;
    logic   active, win_end, restart, do_snap;
    cnt_t   win_cnt_q;

    always_comb begin
        state_d = state_q;
        active  = 1'b0;
        case (state_q)
            IDLE: if (en_i) begin
                state_d = RUN;
                active  = 1'b1;
            end
            RUN: if (en_i) active = 1'b1;
                 else state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign win_end = (WindowCycles != 0) && active
                  && (win_cnt_q == cnt_t'(WindowCycles - 1));
    assign restart = clear_i || snap_i || win_end;
    assign do_snap = (snap_i || win_end) && !clear_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            win_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (restart)     win_cnt_q <= '0;
            else if (active) win_cnt_q <= win_cnt_q + 1'b1;
        end
    end

    cnt_t r_beats_q, w_beats_q, rd_txn_q, wr_txn_q;
    cnt_t rd_sum_q, wr_sum_q, rd_max_q, wr_max_q;
    cnt_t r_beats_d, w_beats_d, rd_txn_d, wr_txn_d;
    cnt_t rd_sum_d, wr_sum_d, rd_max_d, wr_max_d;

    // Events in a restart cycle open the new window rather than close the old one.
    always_comb begin
        r_beats_d = restart ? '0 : r_beats_q;
        w_beats_d = restart ? '0 : w_beats_q;
        rd_txn_d  = restart ? '0 : rd_txn_q;
        wr_txn_d  = restart ? '0 : wr_txn_q;
        rd_sum_d  = restart ? '0 : rd_sum_q;
        wr_sum_d  = restart ? '0 : wr_sum_q;
        rd_max_d  = restart ? '0 : rd_max_q;
        wr_max_d  = restart ? '0 : wr_max_q;
        if (active) begin
            r_beats_d = sat_add(r_beats_d, cnt_t'(r_hs));
            w_beats_d = sat_add(w_beats_d, cnt_t'(w_hs));
            if (rd_meas) begin
                rd_txn_d = sat_add(rd_txn_d, cnt_t'(1));
                rd_sum_d = sat_add(rd_sum_d, rd_lat);
                if (rd_lat > rd_max_d) rd_max_d = rd_lat;
            end
            if (wr_meas) begin
                wr_txn_d = sat_add(wr_txn_d, cnt_t'(1));
                wr_sum_d = sat_add(wr_sum_d, wr_lat);
                if (wr_lat > wr_max_d) wr_max_d = wr_lat;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_beats_q     <= '0;
            w_beats_q     <= '0;
            rd_txn_q      <= '0;
            wr_txn_q      <= '0;
            rd_sum_q      <= '0;
            wr_sum_q      <= '0;
            rd_max_q      <= '0;
            wr_max_q      <= '0;
            r_beats_o     <= '0;
            w_beats_o     <= '0;
            rd_txn_o      <= '0;
            wr_txn_o      <= '0;
            rd_lat_sum_o  <= '0;
            wr_lat_sum_o  <= '0;
            rd_lat_max_o  <= '0;
            wr_lat_max_o  <= '0;
            stats_valid_o <= 1'b0;
        end else begin
            r_beats_q     <= r_beats_d;
            w_beats_q     <= w_beats_d;
            rd_txn_q      <= rd_txn_d;
            wr_txn_q      <= wr_txn_d;
            rd_sum_q      <= rd_sum_d;
            wr_sum_q      <= wr_sum_d;
            rd_max_q      <= rd_max_d;
            wr_max_q      <= wr_max_d;
            stats_valid_o <= do_snap;
            if (do_snap) begin
                r_beats_o    <= r_beats_q;
                w_beats_o    <= w_beats_q;
                rd_txn_o     <= rd_txn_q;
                wr_txn_o     <= wr_txn_q;
                rd_lat_sum_o <= rd_sum_q;
                wr_lat_sum_o <= wr_sum_q;
                rd_lat_max_o <= rd_max_q;
                wr_lat_max_o <= wr_max_q;
            end
        end
    end

`ifdef AXI_PERF_MONITOR_MIN_LAT_EN
    cnt_t rd_min_q, wr_min_q, rd_min_d, wr_min_d;

    always_comb begin
        rd_min_d = restart ? Ones : rd_min_q;
        wr_min_d = restart ? Ones : wr_min_q;
        if (active && rd_meas && (rd_lat < rd_min_d)) rd_min_d = rd_lat;
        if (active && wr_meas && (wr_lat < wr_min_d)) wr_min_d = wr_lat;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_min_q     <= Ones;
            wr_min_q     <= Ones;
            rd_lat_min_o <= Ones;
            wr_lat_min_o <= Ones;
        end else begin
            rd_min_q <= rd_min_d;
            wr_min_q <= wr_min_d;
            if (do_snap) begin
                rd_lat_min_o <= rd_min_q;
                wr_lat_min_o <= wr_min_q;
            end
        end
    end
`else
    assign rd_lat_min_o = Ones;
    assign wr_lat_min_o = Ones;
`endif

endmodule
